bi_directional_deshift: RTL and testbench
=========================================

BI_DIRECTIONAL_DESHIFT -- requirements
Module: bi_directional_deshift

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-003 SHALL have port ser_in, input, 1 bit: serial data bit.
REQ-004 SHALL have port ser_valid, input, 1 bit: ser_in is valid this cycle.
REQ-005 SHALL have port ser_ready, output, 1 bit: block accepts a bit this cycle. A bit transfers only when ser_valid=1 and ser_ready=1.
REQ-006 SHALL have port shift_direction, input, 1 bit: 0 = MSB-first (shift left), 1 = LSB-first (shift right).
REQ-007 SHALL have port frame_len, input, 3 bits: data bits per frame minus 1 (0 gives 1 bit, 7 gives 8 bits).
REQ-008 SHALL have port d_out, output, 8 bits: assembled word, right-aligned, unused upper bits 0.
REQ-009 SHALL have port d_valid, output, 1 bit: d_out holds a complete word.
REQ-010 SHALL have port d_ready, input, 1 bit: consumer accepts d_out.
REQ-011 SHALL have port parity_err, output, 1 bit: parity mismatch flag (see Configuration).

Function
REQ-012 SHALL implement states IDLE, SHIFT, PARITY (macro only) and HOLD.
REQ-013 ser_ready SHALL be 1 in IDLE, SHIFT and PARITY, and 0 in HOLD.
REQ-014 In IDLE, a transfer SHALL latch shift_direction and frame_len for the whole frame and store the first bit. The bit count becomes 1.
REQ-015 Changes to shift_direction or frame_len after the first bit of a frame SHALL have no effect until the next frame.
REQ-016 With direction 0, each transfer SHALL do shreg <= {shreg[6:0], ser_in}.
REQ-017 With direction 1, each transfer SHALL do shreg <= {ser_in, shreg[7:1]}. At frame end, the word SHALL be right-shifted by 7-frame_len.
REQ-018 Cycles with ser_valid=0 SHALL hold state and count unchanged. There is no timeout.
REQ-019 When the transfer count reaches frame_len+1, the next state SHALL be HOLD (or PARITY with the macro). For frame_len=0 this happens directly from IDLE.
REQ-020 d_valid SHALL assert the cycle after the last data (or parity) bit is accepted. Latency is 1 clock.
REQ-021 In HOLD, d_out and parity_err SHALL stay stable until d_ready=1, then return to IDLE on the next edge.
REQ-022 A bit presented in the cycle HOLD exits SHALL NOT be accepted, because ser_ready=0.
REQ-023 The bit counter SHALL be 4 bits wide and SHALL never wrap. It clears on entry to IDLE.

Reset
REQ-024 When reset=1 at a clock edge, the block SHALL enter IDLE and clear shreg, the count, d_out and parity_err; d_valid becomes 0 and ser_ready becomes 1.
REQ-025 Reset SHALL override all other inputs, including mid-frame and in HOLD. A partial frame is discarded with no d_valid pulse.

Configuration
REQ-026 With macro PARITY_CHECK_EN defined, the PARITY state SHALL accept one extra bit after the data bits.
REQ-027 In that case, parity_err SHALL be set to the XOR of all data bits and the parity bit (even parity; 1 = error), valid while d_valid=1.
REQ-028 Without PARITY_CHECK_EN, the PARITY state SHALL NOT exist, frames SHALL be data bits only, and parity_err SHALL be tied 0.

Verification
REQ-029 Bench SHALL apply dir=0, len=7, bits 0,0,1,0,0,0,0,0 (MSB first) and require d_out=8'h20 with d_valid 1 clock after the last bit.
REQ-030 Bench SHALL apply dir=1, len=7, bits 0,0,0,0,1,0,0,0 (LSB first) and require d_out=8'h10.
REQ-031 Bench SHALL apply dir=0, len=2, bits 1,0,1 and require d_out=8'h05; it SHALL also apply dir=1, len=2, bits 1,0,1 and require d_out=8'h05.
REQ-032 Bench SHALL hold d_ready=0 for 5 clocks in HOLD while ser_valid=1 and require d_out stable, ser_ready=0, and the extra bits ignored; after d_ready=1, it requires IDLE next cycle.
REQ-033 Bench SHALL assert reset after 4 of 8 bits and require d_valid=0 and d_out=0; a following full frame of 8'hA5 SHALL yield 8'hA5.
REQ-034 Under PARITY_CHECK_EN, bench SHALL send 8'h03 with parity bit 0 and require parity_err=0, then parity bit 1 and require parity_err=1.

Source files
------------

// File: rtl/bi_directional_deshift.sv
// Serial-to-parallel deshifter with per-frame direction/length and a ready/valid handshake on both sides.
// Optional even-parity check on one trailing bit per frame when PARITY_CHECK_EN is defined.
module bi_directional_deshift (
    input  logic       clk,
    input  logic       reset,
    input  logic       ser_in,
    input  logic       ser_valid,
    output logic       ser_ready,
    input  logic       shift_direction,
    input  logic [2:0] frame_len,
    output logic [7:0] d_out,
    output logic       d_valid,
    input  logic       d_ready,
    output logic       parity_err
);

`ifdef PARITY_CHECK_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY, HOLD} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;
`endif

    state_t     state_q, state_d;
    logic [7:0] shreg_q, shreg_d;
    logic [3:0] cnt_q,   cnt_d;
    logic       dir_q,   dir_d;
    logic [2:0] len_q,   len_d;
    logic [7:0] dout_q,  dout_d;

    logic       xfer;
    logic       dir_eff;
    logic [2:0] len_eff;
    logic [7:0] base;
    logic [7:0] shifted;
    logic [3:0] cnt_inc;
    logic       last;

    // LSB-first words sit at the top of shreg; MSB-first words only need masking.
    function automatic logic [7:0] align(input logic [7:0] s, input logic dir, input logic [2:0] len);
        if (dir)
            return s >> (3'd7 - len);
        else
            return s & (8'hFF >> (3'd7 - len));
    endfunction

    assign ser_ready = (state_q != HOLD);
    assign d_valid   = (state_q == HOLD);
    assign d_out     = dout_q;
    assign xfer      = ser_valid && ser_ready;

    // The first bit of a frame uses the live direction/length inputs and an empty register.
    always_comb begin
        dir_eff = (state_q == IDLE) ? shift_direction : dir_q;
        len_eff = (state_q == IDLE) ? frame_len       : len_q;
        base    = (state_q == IDLE) ? 8'h00           : shreg_q;
        shifted = dir_eff ? {ser_in, base[7:1]} : {base[6:0], ser_in};
        if (state_q == IDLE)
            cnt_inc = 4'd1;
        else
            cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
        last = (cnt_inc == ({1'b0, len_eff} + 4'd1));
    end

`ifdef PARITY_CHECK_EN
    logic perr_q, perr_d;
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        len_d   = len_q;
        dout_d  = dout_q;
`ifdef PARITY_CHECK_EN
        perr_d  = perr_q;
`endif
        case (state_q)
            IDLE, SHIFT: begin
                if (xfer) begin
                    dir_d   = dir_eff;
                    len_d   = len_eff;
                    shreg_d = shifted;
                    cnt_d   = cnt_inc;
                    state_d = SHIFT;
                    if (last) begin
`ifdef PARITY_CHECK_EN
                        state_d = PARITY;
`else
                        dout_d  = align(shifted, dir_eff, len_eff);
                        state_d = HOLD;
`endif
                    end
                end
            end
`ifdef PARITY_CHECK_EN
            PARITY: begin
                if (xfer) begin
                    // Unused shreg bits are zero, so a full reduction equals the data-bit XOR.
                    dout_d  = align(shreg_q, dir_q, len_q);
                    perr_d  = (^shreg_q) ^ ser_in;
                    state_d = HOLD;
                end
            end
`endif
            HOLD: begin
                if (d_ready) begin
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    shreg_d = 8'h00;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= 8'h00;
            cnt_q   <= 4'd0;
            dir_q   <= 1'b0;
            len_q   <= 3'd0;
            dout_q  <= 8'h00;
`ifdef PARITY_CHECK_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            len_q   <= len_d;
            dout_q  <= dout_d;
`ifdef PARITY_CHECK_EN
            perr_q  <= perr_d;
`endif
        end
    end

endmodule

// File: tb/tb_bi_directional_deshift.sv
// Directed bench for bi_directional_deshift; frames are given as seq[7] sent first, seq[6] next, and so on.
module tb_bi_directional_deshift;

    logic       clk = 1'b0;
    logic       reset;
    logic       ser_in;
    logic       ser_valid;
    logic       ser_ready;
    logic       shift_direction;
    logic [2:0] frame_len;
    logic [7:0] d_out;
    logic       d_valid;
    logic       d_ready;
    logic       parity_err;

    int checks = 0;
    int errors = 0;

    bi_directional_deshift dut (
        .clk             (clk),
        .reset           (reset),
        .ser_in          (ser_in),
        .ser_valid       (ser_valid),
        .ser_ready       (ser_ready),
        .shift_direction (shift_direction),
        .frame_len       (frame_len),
        .d_out           (d_out),
        .d_valid         (d_valid),
        .d_ready         (d_ready),
        .parity_err      (parity_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic even_par(input logic [7:0] seq, input logic [2:0] len);
        logic p;
        p = 1'b0;
        for (int i = 0; i <= 7; i++)
            if (i <= int'(len)) p ^= seq[7-i];
        return p;
    endfunction

    // Sends one frame; direction/length are scrambled after the first bit to prove they were latched.
    // Returns after the edge that accepts the final bit (data, or parity when enabled).
    task automatic send_frame(input string tag, input logic dir, input logic [2:0] len,
                              input logic [7:0] seq, input logic pbit);
        int nbits;
        nbits = int'(len) + 1;
`ifdef PARITY_CHECK_EN
        nbits = nbits + 1;
`endif
        shift_direction = dir;
        frame_len       = len;
        for (int i = 0; i < nbits; i++) begin
            ser_valid = 1'b1;
            ser_in    = (i <= int'(len)) ? seq[7-i] : pbit;
            step();
            if (i == 0) begin
                shift_direction = ~dir;
                frame_len       = ~len;
            end
            if (i < nbits - 1)
                chk({tag, "_dvalid_mid"}, {7'd0, d_valid}, 8'h00);
        end
        ser_valid = 1'b0;
        ser_in    = 1'b0;
    endtask

    task automatic release_word(input string tag);
        d_ready = 1'b1;
        step();
        d_ready = 1'b0;
        chk({tag, "_idle_dvalid"}, {7'd0, d_valid}, 8'h00);
        chk({tag, "_idle_ready"}, {7'd0, ser_ready}, 8'h01);
    endtask

    initial begin
        reset = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; shift_direction = 1'b0;
        frame_len = 3'd0; d_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        chk("rst_dvalid", {7'd0, d_valid}, 8'h00);
        chk("rst_ready",  {7'd0, ser_ready}, 8'h01);
        chk("rst_dout",   d_out, 8'h00);
        chk("rst_perr",   {7'd0, parity_err}, 8'h00);

        // Idle cycles with no valid bits do nothing
        step(); step();
        chk("idle_hold", {7'd0, d_valid}, 8'h00);

        send_frame("msb8", 1'b0, 3'd7, 8'b0010_0000, even_par(8'b0010_0000, 3'd7));
        chk("msb8_dvalid", {7'd0, d_valid}, 8'h01);
        chk("msb8_dout",   d_out, 8'h20);
        chk("msb8_ready",  {7'd0, ser_ready}, 8'h00);
        release_word("msb8");

        send_frame("lsb8", 1'b1, 3'd7, 8'b0000_1000, even_par(8'b0000_1000, 3'd7));
        chk("lsb8_dvalid", {7'd0, d_valid}, 8'h01);
        chk("lsb8_dout",   d_out, 8'h10);
        release_word("lsb8");

        send_frame("msb3", 1'b0, 3'd2, 8'b1010_0000, even_par(8'b1010_0000, 3'd2));
        chk("msb3_dout", d_out, 8'h05);
        release_word("msb3");

        send_frame("lsb3", 1'b1, 3'd2, 8'b1010_0000, even_par(8'b1010_0000, 3'd2));
        chk("lsb3_dout", d_out, 8'h05);
        release_word("lsb3");

        send_frame("lsb4", 1'b1, 3'd3, 8'b1100_0000, even_par(8'b1100_0000, 3'd3));
        chk("lsb4_dout", d_out, 8'h03);
        release_word("lsb4");

        // Stall in HOLD with bits offered: all must be refused
        send_frame("hold", 1'b0, 3'd7, 8'hA5, even_par(8'hA5, 3'd7));
        for (int k = 0; k < 5; k++) begin
            ser_valid = 1'b1;
            ser_in    = k[0];
            step();
            chk("hold_dout",   d_out, 8'hA5);
            chk("hold_ready",  {7'd0, ser_ready}, 8'h00);
            chk("hold_dvalid", {7'd0, d_valid}, 8'h01);
        end
        // Exit cycle: bit 1 offered but not accepted
        ser_valid = 1'b1;
        ser_in    = 1'b1;
        d_ready   = 1'b1;
        step();
        ser_valid = 1'b0;
        ser_in    = 1'b0;
        d_ready   = 1'b0;
        chk("hold_exit_dvalid", {7'd0, d_valid}, 8'h00);
        chk("hold_exit_ready",  {7'd0, ser_ready}, 8'h01);

        // Single-bit frame; a leaked exit-cycle bit would have altered this result
        send_frame("len1", 1'b0, 3'd0, 8'b0000_0000, 1'b0);
        chk("len1_dvalid", {7'd0, d_valid}, 8'h01);
        chk("len1_dout",   d_out, 8'h00);
        release_word("len1");

        send_frame("len1b", 1'b1, 3'd0, 8'b1000_0000, 1'b1);
        chk("len1b_dout", d_out, 8'h01);
        release_word("len1b");

        // Reset after 4 of 8 bits discards the partial frame
        shift_direction = 1'b0;
        frame_len       = 3'd7;
        for (int i = 0; i < 4; i++) begin
            ser_valid = 1'b1;
            ser_in    = 1'b1;
            step();
        end
        ser_valid = 1'b0;
        reset     = 1'b1;
        step();
        reset     = 1'b0;
        chk("midrst_dvalid", {7'd0, d_valid}, 8'h00);
        chk("midrst_dout",   d_out, 8'h00);
        chk("midrst_ready",  {7'd0, ser_ready}, 8'h01);
        step();
        chk("midrst_nopulse", {7'd0, d_valid}, 8'h00);

        send_frame("postrst", 1'b0, 3'd7, 8'hA5, even_par(8'hA5, 3'd7));
        chk("postrst_dvalid", {7'd0, d_valid}, 8'h01);
        chk("postrst_dout",   d_out, 8'hA5);
        chk("postrst_perr",   {7'd0, parity_err}, 8'h00);
        release_word("postrst");

`ifdef PARITY_CHECK_EN
        send_frame("par0", 1'b0, 3'd7, 8'h03, 1'b0);
        chk("par0_dout", d_out, 8'h03);
        chk("par0_perr", {7'd0, parity_err}, 8'h00);
        release_word("par0");
        send_frame("par1", 1'b0, 3'd7, 8'h03, 1'b1);
        chk("par1_dout", d_out, 8'h03);
        chk("par1_perr", {7'd0, parity_err}, 8'h01);
        release_word("par1");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
